// File: rtl/arith_encoder_scheduler.sv
// Symbol sequencer for the arithmetic encoder: input FIFO, paced issue, pipeline drain, flush, frame report.
// Optional build macro SCHED_PARAM_CHECK_EN adds param_err and drops malformed CDF entries.
module arith_encoder_scheduler #(
  parameter int RANGE_WIDTH  = 16,
  parameter int SYMBOL_WIDTH = 4,
  parameter int FIFO_DEPTH   = 4,
  parameter int PIPE_DEPTH   = 3,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                    general_clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [RANGE_WIDTH-1:0]  in_fl,
  input  logic [RANGE_WIDTH-1:0]  in_fh,
  input  logic [SYMBOL_WIDTH-1:0] in_symbol,
  input  logic [SYMBOL_WIDTH:0]   in_nsyms,
  input  logic                    in_last,
  output logic                    enc_valid,
  output logic [RANGE_WIDTH-1:0]  enc_fl,
  output logic [RANGE_WIDTH-1:0]  enc_fh,
  output logic [SYMBOL_WIDTH-1:0] enc_symbol,
  output logic [SYMBOL_WIDTH:0]   enc_nsyms,
  input  logic                    enc_stall,
  output logic                    flush_req,
  input  logic                    flush_done,
  output logic                    frame_done,
  output logic [CNT_WIDTH-1:0]    symbol_count,
`ifdef SCHED_PARAM_CHECK_EN
  output logic                    param_err,
`endif
  output logic                    busy
);

  // state | meaning
  // IDLE  | waiting for a queued entry
  // RUN   | popping and issuing entries until the last of the frame
  // DRAIN | letting the encoder pipeline settle (PIPE_DEPTH unstalled cycles)
  // FLUSH | flush_req held until flush_done
  // DONE  | one-cycle frame_done pulse
  typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_FLUSH, S_DONE} state_t;

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int DRN_W   = $clog2(PIPE_DEPTH + 1);
  localparam int ENTRY_W = 2 * RANGE_WIDTH + 2 * SYMBOL_WIDTH + 2;
  localparam logic [PTR_W:0]   DEPTH_C = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [DRN_W-1:0] PIPE_C  = DRN_W'(PIPE_DEPTH);

  state_t                 state_q, state_d;
  logic [ENTRY_W-1:0]     mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]         cnt_q;
  logic [DRN_W-1:0]       drain_q, drain_d;
  logic [CNT_WIDTH-1:0]   sym_cnt_q;
  logic                   enc_valid_q;
  logic [RANGE_WIDTH-1:0] enc_fl_q, enc_fh_q;
  logic [SYMBOL_WIDTH-1:0] enc_sym_q;
  logic [SYMBOL_WIDTH:0]  enc_ns_q;

  logic                    full, empty, push, pop, issue, hd_bad, clr_cnt;
  logic [RANGE_WIDTH-1:0]  hd_fl, hd_fh;
  logic [SYMBOL_WIDTH-1:0] hd_sym;
  logic [SYMBOL_WIDTH:0]   hd_nsyms;
  logic                    hd_last;

  assign full     = (cnt_q == DEPTH_C);
  assign empty    = (cnt_q == '0);
  assign in_ready = reset && !full;
  assign push     = in_valid && in_ready;
  assign pop      = (state_q == S_RUN) && !empty && !enc_stall;
  assign {hd_last, hd_nsyms, hd_sym, hd_fh, hd_fl} = mem_q[rd_ptr_q];

`ifdef SCHED_PARAM_CHECK_EN
  logic param_err_q;
  // AV1 CDFs are inverted, so a well-formed entry has fh <= fl.
  assign hd_bad    = (hd_nsyms == '0) || ({1'b0, hd_sym} >= hd_nsyms) || (hd_fh > hd_fl);
  assign param_err = param_err_q;
  always_ff @(posedge general_clk) begin
    if (!reset)             param_err_q <= 1'b0;
    else if (pop && hd_bad) param_err_q <= 1'b1;
  end
`else
  assign hd_bad = 1'b0;
`endif

  assign issue = pop && !hd_bad;

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    clr_cnt = 1'b0;
    case (state_q)
      S_IDLE: if (!empty) begin
        state_d = S_RUN;
        clr_cnt = 1'b1;
      end
      S_RUN: if (pop && hd_last) begin
        state_d = S_DRAIN;
        drain_d = PIPE_C;
      end
      S_DRAIN: if (!enc_stall) begin
        if (drain_q <= DRN_W'(1)) begin
          state_d = S_FLUSH;
          drain_d = '0;
        end else begin
          drain_d = drain_q - DRN_W'(1);
        end
      end
      S_FLUSH: if (flush_done) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge general_clk) begin
    if (push) mem_q[wr_ptr_q] <= {in_last, in_nsyms, in_symbol, in_fh, in_fl};
  end

  always_ff @(posedge general_clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      drain_q     <= '0;
      sym_cnt_q   <= '0;
      enc_valid_q <= 1'b0;
      enc_fl_q    <= '0;
      enc_fh_q    <= '0;
      enc_sym_q   <= '0;
      enc_ns_q    <= '0;
    end else begin
      state_q     <= state_d;
      drain_q     <= drain_d;
      enc_valid_q <= issue;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + (PTR_W + 1)'(1);
        2'b01:   cnt_q <= cnt_q - (PTR_W + 1)'(1);
        default: cnt_q <= cnt_q;
      endcase
      if (issue) begin
        enc_fl_q  <= hd_fl;
        enc_fh_q  <= hd_fh;
        enc_sym_q <= hd_sym;
        enc_ns_q  <= hd_nsyms;
      end
      if (clr_cnt)                          sym_cnt_q <= '0;
      else if (issue && (sym_cnt_q != '1))  sym_cnt_q <= sym_cnt_q + CNT_WIDTH'(1);
    end
  end

  assign enc_valid    = enc_valid_q;
  assign enc_fl       = enc_fl_q;
  assign enc_fh       = enc_fh_q;
  assign enc_symbol   = enc_sym_q;
  assign enc_nsyms    = enc_ns_q;
  assign symbol_count = sym_cnt_q;
  assign flush_req    = (state_q == S_FLUSH);
  assign frame_done   = (state_q == S_DONE);
  assign busy         = (state_q != S_IDLE) || !empty;

endmodule

// File: tb/tb_arith_encoder_scheduler.sv
// Directed bench for arith_encoder_scheduler; inputs change 1ns after the rising edge, outputs are sampled on the falling edge.
// Build with SCHED_PARAM_CHECK_EN defined to exercise the parameter-check variant.
module tb_arith_encoder_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_fl, in_fh;
  logic [3:0]  in_symbol;
  logic [4:0]  in_nsyms;
  logic        in_last;
  logic        enc_valid;
  logic [15:0] enc_fl, enc_fh;
  logic [3:0]  enc_symbol;
  logic [4:0]  enc_nsyms;
  logic        enc_stall;
  logic        flush_req;
  logic        flush_done;
  logic        frame_done;
  logic [15:0] symbol_count;
  logic        busy;
`ifdef SCHED_PARAM_CHECK_EN
  logic        param_err;
`endif

  int nvec = 0;
  int nerr = 0;

  arith_encoder_scheduler dut (
    .general_clk (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_fl       (in_fl),
    .in_fh       (in_fh),
    .in_symbol   (in_symbol),
    .in_nsyms    (in_nsyms),
    .in_last     (in_last),
    .enc_valid   (enc_valid),
    .enc_fl      (enc_fl),
    .enc_fh      (enc_fh),
    .enc_symbol  (enc_symbol),
    .enc_nsyms   (enc_nsyms),
    .enc_stall   (enc_stall),
    .flush_req   (flush_req),
    .flush_done  (flush_done),
    .frame_done  (frame_done),
    .symbol_count(symbol_count),
`ifdef SCHED_PARAM_CHECK_EN
    .param_err   (param_err),
`endif
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // issue monitor: records every enc_valid beat with the cycle it appeared in
  int          cyc_n = 0;
  int          mon_n = 0;
  logic [15:0] mon_fl [64];
  logic [3:0]  mon_sym [64];
  int          mon_cyc [64];

  always @(posedge clk) cyc_n++;
  always @(negedge clk) begin
    if (enc_valid === 1'b1 && mon_n < 64) begin
      mon_fl[mon_n]  = enc_fl;
      mon_sym[mon_n] = enc_symbol;
      mon_cyc[mon_n] = cyc_n;
      mon_n++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] fl, input logic [15:0] fh, input logic [3:0] sym,
                      input logic [4:0] ns, input logic last);
    in_valid  = 1'b1;
    in_fl     = fl;
    in_fh     = fh;
    in_symbol = sym;
    in_nsyms  = ns;
    in_last   = last;
    cyc;
    in_valid  = 1'b0;
    in_last   = 1'b0;
  endtask

  task automatic finish_frame(input string tag);
    for (int k = 0; k < 40; k++) begin
      if (flush_req === 1'b1) break;
      cyc;
    end
    @(negedge clk);
    chk({tag, "_flush_req"}, 32'(flush_req), 32'd1);
    flush_done = 1'b1;
    cyc;
    flush_done = 1'b0;
    @(negedge clk);
    chk({tag, "_frame_done"}, 32'(frame_done), 32'd1);
    cyc;
    @(negedge clk);
    chk({tag, "_frame_done_pulse"}, 32'(frame_done), 32'd0);
  endtask

  int   base;
  int   i;
  int   guard;
  logic rdy;
  logic saw_full;

  initial begin
    reset      = 1'b0;
    in_valid   = 1'b1;
    in_fl      = 16'h1234;
    in_fh      = 16'h0012;
    in_symbol  = 4'd1;
    in_nsyms   = 5'd4;
    in_last    = 1'b0;
    enc_stall  = 1'b0;
    flush_done = 1'b0;

    // reset held with in_valid high: nothing may be accepted
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_enc_valid", 32'(enc_valid), 32'd0);
      chk("rst_symbol_count", 32'(symbol_count), 32'd0);
    end
    chk("rst_flush_req", 32'(flush_req), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_enc_fl", 32'(enc_fl), 32'd0);
`ifdef SCHED_PARAM_CHECK_EN
    chk("rst_param_err", 32'(param_err), 32'd0);
`endif
    cyc;
    reset    = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    chk("post_rst_busy", 32'(busy), 32'd0);
    cyc;
    @(negedge clk);
    chk("post_rst_no_push", 32'(busy), 32'd0);

    // single-symbol frame: enc_valid two edges after the push edge, drain 3 cycles
    push(16'd9690, 16'd3202, 4'd3, 5'd10, 1'b1);
    @(negedge clk);
    chk("single_t1_busy", 32'(busy), 32'd1);
    chk("single_t1_enc_valid", 32'(enc_valid), 32'd0);
    cyc;
    @(negedge clk);
    chk("single_t2_enc_valid", 32'(enc_valid), 32'd0);
    cyc;
    @(negedge clk);
    chk("single_t3_enc_valid", 32'(enc_valid), 32'd1);
    chk("single_enc_fl", 32'(enc_fl), 32'd9690);
    chk("single_enc_fh", 32'(enc_fh), 32'd3202);
    chk("single_enc_symbol", 32'(enc_symbol), 32'd3);
    chk("single_enc_nsyms", 32'(enc_nsyms), 32'd10);
    chk("single_count", 32'(symbol_count), 32'd1);
    cyc;
    @(negedge clk);
    chk("single_one_beat", 32'(enc_valid), 32'd0);
    chk("single_drain1", 32'(flush_req), 32'd0);
    cyc;
    @(negedge clk);
    chk("single_drain2", 32'(flush_req), 32'd0);
    cyc;
    @(negedge clk);
    chk("single_flush_start", 32'(flush_req), 32'd1);
    cyc;
    @(negedge clk);
    chk("single_flush_hold", 32'(flush_req), 32'd1);
    chk("single_no_early_done", 32'(frame_done), 32'd0);
    flush_done = 1'b1;
    cyc;
    flush_done = 1'b0;
    @(negedge clk);
    chk("single_frame_done", 32'(frame_done), 32'd1);
    chk("single_flush_released", 32'(flush_req), 32'd0);
    cyc;
    @(negedge clk);
    chk("single_frame_done_pulse", 32'(frame_done), 32'd0);
    chk("single_idle_busy", 32'(busy), 32'd0);
    chk("single_count_hold", 32'(symbol_count), 32'd1);

    // 8-symbol burst; stall until the FIFO reports full, then issue back-to-back
    cyc;
    base      = mon_n;
    enc_stall = 1'b1;
    i         = 0;
    guard     = 0;
    saw_full  = 1'b0;
    while (i < 8 && guard < 60) begin
      in_valid  = 1'b1;
      in_fl     = 16'h8000 + 16'(i);
      in_fh     = 16'h1000 + 16'(i);
      in_symbol = 4'(i);
      in_nsyms  = 5'd10;
      in_last   = (i == 7);
      @(negedge clk);
      rdy = in_ready;
      if (!rdy) saw_full = 1'b1;
      if (saw_full) enc_stall = 1'b0;
      cyc;
      if (rdy) i++;
      guard++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("burst_in_ready_dropped", 32'(saw_full), 32'd1);
    chk("burst_all_pushed", 32'(i), 32'd8);
    finish_frame("burst");
    chk("burst_beats", 32'(mon_n - base), 32'd8);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("burst_sym%0d", k), 32'(mon_sym[base + k]), 32'(k));
      chk($sformatf("burst_fl%0d", k), 32'(mon_fl[base + k]), 32'h8000 + 32'(k));
    end
    chk("burst_back_to_back", 32'(mon_cyc[base + 7] - mon_cyc[base]), 32'd7);
    chk("burst_count", 32'(symbol_count), 32'd8);

    // stall mid-frame holds enc_*, stall in DRAIN extends it by 5 cycles
    cyc;
    base      = mon_n;
    enc_stall = 1'b1;
    push(16'h4010, 16'h0101, 4'd1, 5'd9, 1'b0);
    push(16'h4020, 16'h0102, 4'd2, 5'd9, 1'b0);
    push(16'h4030, 16'h0103, 4'd3, 5'd9, 1'b1);
    enc_stall = 1'b0;
    cyc;
    enc_stall = 1'b1;
    @(negedge clk);
    chk("stall_first_issue", 32'(enc_valid), 32'd1);
    chk("stall_first_sym", 32'(enc_symbol), 32'd1);
    for (int k = 0; k < 5; k++) begin
      cyc;
      @(negedge clk);
      chk("stall_no_issue", 32'(enc_valid), 32'd0);
      chk("stall_hold_sym", 32'(enc_symbol), 32'd1);
      chk("stall_hold_fl", 32'(enc_fl), 32'h4010);
    end
    enc_stall = 1'b0;
    cyc;
    @(negedge clk);
    chk("stall_resume_sym", 32'(enc_symbol), 32'd2);
    cyc;
    enc_stall = 1'b1;
    @(negedge clk);
    chk("stall_last_sym", 32'(enc_symbol), 32'd3);
    chk("stall_last_valid", 32'(enc_valid), 32'd1);
    for (int k = 0; k < 5; k++) begin
      cyc;
      @(negedge clk);
      chk("drain_stall_no_flush", 32'(flush_req), 32'd0);
      chk("drain_stall_no_issue", 32'(enc_valid), 32'd0);
    end
    enc_stall = 1'b0;
    cyc;
    @(negedge clk);
    chk("drain_after_stall1", 32'(flush_req), 32'd0);
    cyc;
    @(negedge clk);
    chk("drain_after_stall2", 32'(flush_req), 32'd0);
    cyc;
    @(negedge clk);
    chk("drain_extended_flush", 32'(flush_req), 32'd1);
    chk("stall_beats", 32'(mon_n - base), 32'd3);
    chk("stall_count", 32'(symbol_count), 32'd3);

    // next frame queued during FLUSH waits for frame_done, counter restarts
    push(16'h2222, 16'h0011, 4'd5, 5'd6, 1'b1);
    @(negedge clk);
    chk("f2_queued_busy", 32'(busy), 32'd1);
    chk("f2_not_issued", 32'(enc_valid), 32'd0);
    chk("f2_count_hold", 32'(symbol_count), 32'd3);
    cyc;
    @(negedge clk);
    chk("f2_flush_hold", 32'(flush_req), 32'd1);
    flush_done = 1'b1;
    cyc;
    flush_done = 1'b0;
    @(negedge clk);
    chk("f1_frame_done", 32'(frame_done), 32'd1);
    chk("f1_count_at_done", 32'(symbol_count), 32'd3);
    cyc;
    @(negedge clk);
    chk("f2_idle_no_issue", 32'(enc_valid), 32'd0);
    chk("f2_idle_count", 32'(symbol_count), 32'd3);
    cyc;
    @(negedge clk);
    chk("f2_count_cleared", 32'(symbol_count), 32'd0);
    chk("f2_run_no_issue", 32'(enc_valid), 32'd0);
    cyc;
    @(negedge clk);
    chk("f2_issue", 32'(enc_valid), 32'd1);
    chk("f2_sym", 32'(enc_symbol), 32'd5);
    chk("f2_count", 32'(symbol_count), 32'd1);
    finish_frame("f2");

    // symbol == nsyms: dropped when checking is built in, forwarded otherwise
    cyc;
    base = mon_n;
    push(16'd500, 16'd100, 4'd10, 5'd10, 1'b1);
    cyc;
    cyc;
    @(negedge clk);
`ifdef SCHED_PARAM_CHECK_EN
    chk("perr_dropped", 32'(enc_valid), 32'd0);
    chk("perr_flag", 32'(param_err), 32'd1);
    chk("perr_count", 32'(symbol_count), 32'd0);
`else
    chk("nochk_forwarded", 32'(enc_valid), 32'd1);
    chk("nochk_sym", 32'(enc_symbol), 32'd10);
    chk("nochk_count", 32'(symbol_count), 32'd1);
`endif
    finish_frame("perr");
`ifdef SCHED_PARAM_CHECK_EN
    chk("perr_sticky", 32'(param_err), 32'd1);
    chk("perr_beats", 32'(mon_n - base), 32'd0);
`else
    chk("nochk_beats", 32'(mon_n - base), 32'd1);
`endif
    chk("end_busy", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/arith_encoder_scheduler.md
Name: arith_encoder_scheduler

Overview:
Sequencer in front of the arithmetic_encoder datapath. Accepts per-symbol CDF parameters (fl, fh, symbol, nsyms) from an upstream producer via valid/ready and buffers them in a small FIFO. Issues at most one symbol per cycle into the encoder while honouring encoder stall. On frame end, drains the encoder pipeline, runs a flush handshake, then reports frame completion and the symbol count.

Parameters:
RANGE_WIDTH, 16, width of fl/fh
SYMBOL_WIDTH, 4, width of symbol; nsyms is SYMBOL_WIDTH+1
FIFO_DEPTH, 4, input FIFO entries (power of two, >=2)
PIPE_DEPTH, 3, encoder pipeline latency in cycles from issue to range/low update
CNT_WIDTH, 16, width of symbol counter

Ports:
general_clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-low reset
in_valid  in  1  upstream entry valid
in_ready  out  1  FIFO can accept (not full)
in_fl  in  RANGE_WIDTH  CDF low
in_fh  in  RANGE_WIDTH  CDF high
in_symbol  in  SYMBOL_WIDTH  symbol
in_nsyms  in  SYMBOL_WIDTH+1  alphabet size
in_last  in  1  entry is the last of the frame
enc_valid  out  1  issue strobe to encoder
enc_fl  out  RANGE_WIDTH  to general_fl
enc_fh  out  RANGE_WIDTH  to general_fh
enc_symbol  out  SYMBOL_WIDTH  to general_symbol
enc_nsyms  out  SYMBOL_WIDTH+1  to general_nsyms
enc_stall  in  1  encoder cannot take a symbol this cycle
flush_req  out  1  request encoder final flush
flush_done  in  1  encoder flush complete (1-cycle pulse)
frame_done  out  1  1-cycle pulse, frame finished
symbol_count  out  CNT_WIDTH  symbols issued in current/last frame
busy  out  1  state != IDLE or FIFO non-empty

Behaviour:
- Reset (reset==0 at edge): FIFO emptied, state IDLE, all outputs 0 (in_ready=1 after reset deasserts), symbol_count=0. Reset mid-frame abandons frame; no frame_done.
- FIFO: push when in_valid && in_ready; in_ready = !full (registered count, no same-cycle pop bypass). Push and pop in same cycle when full is not allowed since in_ready=0; when non-full, simultaneous push/pop keeps count. Pointers wrap modulo FIFO_DEPTH. in_last stored per entry.
- Issue: enc_* registered; enc_valid=1 in cycle after pop. Pop when state RUN, FIFO non-empty, enc_stall==0. While enc_stall=1: enc_valid=0, enc_* hold last value. Max throughput 1 symbol/cycle.
- symbol_count increments by 1 per enc_valid, saturates at all-ones, cleared on IDLE->RUN.
- FSM:
  IDLE: FIFO non-empty -> RUN (clear counter).
  RUN: pop entries; popping entry with last=1 -> DRAIN, no further pops this frame.
  DRAIN: counter loads PIPE_DEPTH on entry, decrements only while enc_stall==0; at 0 -> FLUSH.
  FLUSH: flush_req=1 held until flush_done sampled 1 -> DONE. flush_done outside FLUSH ignored.
  DONE: frame_done=1 for one cycle -> IDLE. symbol_count holds until next frame start.
- Entries for the next frame may be accepted into the FIFO during DRAIN/FLUSH/DONE; not issued until IDLE->RUN.
- Frame of exactly one symbol: RUN lasts one issue cycle, then DRAIN.
- Latency: push at cycle t into empty FIFO in IDLE -> enc_valid at t+3 (t+1 IDLE sees non-empty, t+2 RUN pops, t+3 output).

Optional Feature:
SCHED_PARAM_CHECK_EN: when defined, adds output param_err (1 bit, sticky, cleared only by reset). A popped entry with nsyms==0, symbol>=nsyms, or fh>fl (AV1 inverted CDF) is dropped (no enc_valid, not counted) and sets param_err; a dropped last entry still moves to DRAIN. When undefined: no port, all entries forwarded unchecked.

Test Plan:
- Reset: hold reset=0 3 cycles with in_valid=1 -> in_ready=0 during reset, then 1; enc_valid=0, symbol_count=0, no push recorded.
- Single symbol fl=9690 fh=3202 symbol=3 nsyms=10 last=1 -> enc_valid one cycle with those values at t+3; DRAIN 3 cycles; flush_req until flush_done pulse; frame_done pulse; symbol_count=1.
- Burst of 8 symbols, FIFO_DEPTH=4, continuous in_valid -> in_ready drops when 4 queued, enc_valid back-to-back 8 cycles, order preserved, symbol_count=8.
- enc_stall=1 for 5 cycles mid-burst and during DRAIN -> enc_* held, no pops, DRAIN extended by 5 cycles, no loss/duplication.
- Second frame pushed during FLUSH -> held in FIFO, issued only after frame_done; counter restarts at 0.
- With SCHED_PARAM_CHECK_EN: symbol=10 nsyms=10 -> dropped, param_err=1 sticky, symbol_count unchanged; without macro same entry forwarded.
